// File: rtl/mode_reg_pkg.sv
// -----------------------------------------------------------------------------
// mode_reg_pkg
//   Shared definitions for the multi-mode register.
//   - mode_e : 3-bit operation select carried on the mode input
//   - helpers that classify modes
// -----------------------------------------------------------------------------
package mode_reg_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD   = 3'd0,  // q <- q
        MODE_LOAD   = 3'd1,  // q <- d
        MODE_TOGGLE = 3'd2,  // q <- q ^ d (per-bit T flip-flop)
        MODE_UP     = 3'd3,  // q <- q + 1, wrap or saturate at all ones
        MODE_DOWN   = 3'd4,  // q <- q - 1, wrap or saturate at zero
        MODE_SHL    = 3'd5,  // q <- {q[W-2:0], d[0]}
        MODE_SHR    = 3'd6,  // q <- {d[W-1], q[W-1:1]}
        MODE_ROL    = 3'd7   // q <- {q[W-2:0], q[W-1]}
    } mode_e;

    // True for the two modes that can hit a counter limit.
    function automatic logic is_count_mode(input mode_e m);
        return (m == MODE_UP) || (m == MODE_DOWN);
    endfunction

endpackage : mode_reg_pkg

// File: rtl/mode_reg_next.sv
// -----------------------------------------------------------------------------
// mode_reg_next
//   Purely combinational next-state function of the multi-mode register.
//   Computes what q becomes on an enabled edge for the selected mode, and
//   flags the limit event (UP at all ones, DOWN at zero) that drives ovf.
//
// Parameters
//   WIDTH : register width (>= 2)
//   WRAP  : 1 = counter wraps at the limits, 0 = counter saturates
//
// Ports
//   q      in  [WIDTH-1:0]  current register value
//   d      in  [WIDTH-1:0]  load data / toggle mask / serial-in source
//   mode   in  mode_e       operation select
//   q_next out [WIDTH-1:0]  value q takes on an enabled edge
//   evt    out              limit reached (wrap or saturation) this edge
// -----------------------------------------------------------------------------
module mode_reg_next
    import mode_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit WRAP  = 1'b1
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  mode_e            mode,
    output logic [WIDTH-1:0] q_next,
    output logic             evt
);

    logic [WIDTH-1:0] tog_val;
    logic [WIDTH-1:0] shl_val;
    logic [WIDTH-1:0] shr_val;
    logic [WIDTH-1:0] rol_val;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;
    logic             at_max;
    logic             at_min;

    // Per-bit datapath for the bitwise and shifting modes. The end bits
    // differ per mode (serial-in from d or wrap-around from q), the middle
    // bits simply take their neighbour.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign tog_val[gi] = q[gi] ^ d[gi];

        if (gi == 0) begin : g_lsb
            assign shl_val[gi] = d[0];
            assign rol_val[gi] = q[WIDTH-1];
            assign shr_val[gi] = q[gi+1];
        end else if (gi == WIDTH-1) begin : g_msb
            assign shl_val[gi] = q[gi-1];
            assign rol_val[gi] = q[gi-1];
            assign shr_val[gi] = d[WIDTH-1];
        end else begin : g_mid
            assign shl_val[gi] = q[gi-1];
            assign rol_val[gi] = q[gi-1];
            assign shr_val[gi] = q[gi+1];
        end
    end

    assign inc_val = q + WIDTH'(1);
    assign dec_val = q - WIDTH'(1);
    assign at_max  = &q;
    assign at_min  = ~|q;

    always_comb begin
        q_next = q;
        evt    = 1'b0;
        case (mode)
            MODE_HOLD:   q_next = q;
            MODE_LOAD:   q_next = d;
            MODE_TOGGLE: q_next = tog_val;
            MODE_UP: begin
                // The event fires at the limit whether we wrap or saturate.
                if (at_max) begin
                    evt    = 1'b1;
                    q_next = WRAP ? '0 : q;
                end else begin
                    q_next = inc_val;
                end
            end
            MODE_DOWN: begin
                if (at_min) begin
                    evt    = 1'b1;
                    q_next = WRAP ? '1 : q;
                end else begin
                    q_next = dec_val;
                end
            end
            MODE_SHL:    q_next = shl_val;
            MODE_SHR:    q_next = shr_val;
            MODE_ROL:    q_next = rol_val;
            default:     q_next = q;
        endcase
    end

endmodule : mode_reg_next

// File: rtl/mode_reg.sv
// -----------------------------------------------------------------------------
// mode_reg
//   Parametrised multi-mode register: hold, load, per-bit toggle, up/down
//   count (wrap or saturate), shift left/right and rotate, plus synchronous
//   set, a one-cycle overflow/underflow pulse and a zero flag.
//
// Parameters
//   WIDTH   : register width in bits (>= 2)
//   RST_VAL : value of q while/after rst
//   SET_VAL : value loaded by the synchronous set
//   WRAP    : 1 = counter wraps at the limits, 0 = saturates
//
// Ports
//   clk   in                rising-edge clock
//   rst   in                asynchronous reset, active-high
//   set   in                synchronous set, active-high (beats en/mode)
//   en    in                operation enable, 0 = hold
//   mode  in  [2:0]         operation select (mode_reg_pkg::mode_e)
//   d     in  [WIDTH-1:0]   load data / toggle mask / serial-in source
//   q     out [WIDTH-1:0]   registered value
//   ovf   out               registered pulse after a wrap/saturation edge
//   zero  out               combinational q == 0
// -----------------------------------------------------------------------------
module mode_reg
    import mode_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL = '1,
    parameter bit               WRAP    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  d,
    output logic [WIDTH-1:0]  q,
    output logic              ovf,
    output logic              zero
);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             ovf_reg;
    logic             evt_next;

    mode_reg_next #(
        .WIDTH (WIDTH),
        .WRAP  (WRAP)
    ) u_next (
        .q      (q_reg),
        .d      (d),
        .mode   (mode_e'(mode)),
        .q_next (q_next),
        .evt    (evt_next)
    );

    // Priority rst > set > en. ovf is cleared on every edge that is not an
    // enabled limit event, so it can never stretch beyond one cycle unless
    // the limit is hit again (sustained saturation).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg   <= RST_VAL;
            ovf_reg <= 1'b0;
        end else if (set) begin
            q_reg   <= SET_VAL;
            ovf_reg <= 1'b0;
        end else if (en) begin
            q_reg   <= q_next;
            ovf_reg <= evt_next;
        end else begin
            ovf_reg <= 1'b0;
        end
    end

    assign q    = q_reg;
    assign ovf  = ovf_reg;
    assign zero = (q_reg == '0);

endmodule : mode_reg

// File: tb/tb_mode_reg.sv
// -----------------------------------------------------------------------------
// tb_mode_reg
//   Drives a wrapping and a saturating mode_reg (WIDTH=8) from the same
//   inputs. Directed scenarios check the documented cases; a randomized run
//   compares both against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mode_reg;

    logic       clk;
    logic       rst;
    logic       set;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic [7:0] q_w, q_s;
    logic       ovf_w, ovf_s, zero_w, zero_s;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    mode_reg #(.WIDTH(8), .RST_VAL(8'h00), .SET_VAL(8'hFF), .WRAP(1'b1)) dut_w (
        .clk(clk), .rst(rst), .set(set), .en(en), .mode(mode), .d(d),
        .q(q_w), .ovf(ovf_w), .zero(zero_w)
    );

    mode_reg #(.WIDTH(8), .RST_VAL(8'h00), .SET_VAL(8'hFF), .WRAP(1'b0)) dut_s (
        .clk(clk), .rst(rst), .set(set), .en(en), .mode(mode), .d(d),
        .q(q_s), .ovf(ovf_s), .zero(zero_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given inputs; outputs are stable 1 time unit later.
    task automatic cycle(input bit s, input bit e, input logic [2:0] m, input logic [7:0] dd);
        set = s; en = e; mode = m; d = dd;
        @(posedge clk);
        #1;
        txn++;
        $display("txn %0d: set=%0d en=%0d mode=%0d d=%02h | wrap q=%02h ovf=%0d zero=%0d | sat q=%02h ovf=%0d zero=%0d",
                 txn, s, e, m, dd, q_w, ovf_w, zero_w, q_s, ovf_s, zero_s);
    endtask

    // Reference: what the register becomes, from the behavioural rules.
    function automatic void ref_next(input bit wrap, input int q, input bit s, input bit e,
                                     input int m, input int dd, output int nq, output bit no);
        no = 1'b0;
        nq = q;
        if (s) begin
            nq = 255;
        end else if (e) begin
            case (m)
                1: nq = dd;
                2: nq = q ^ dd;
                3: if (q == 255) begin no = 1'b1; nq = wrap ? 0 : 255; end else nq = q + 1;
                4: if (q == 0)   begin no = 1'b1; nq = wrap ? 255 : 0; end else nq = q - 1;
                5: nq = ((q * 2) % 256) + (dd % 2);
                6: nq = (q / 2) + ((dd >= 128) ? 128 : 0);
                7: nq = ((q * 2) % 256) + (q / 128);
                default: nq = q;
            endcase
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1; set = 1'b0; en = 1'b0; mode = 3'd0; d = 8'h00;
        #2;
        total++; if (q_w !== 8'h00 || ovf_w !== 1'b0 || zero_w !== 1'b1) begin bad++;
            $display("FAIL reset_w q=%02h ovf=%0d zero=%0d want 00/0/1", q_w, ovf_w, zero_w); end
        total++; if (q_s !== 8'h00 || ovf_s !== 1'b0 || zero_s !== 1'b1) begin bad++;
            $display("FAIL reset_s q=%02h ovf=%0d zero=%0d want 00/0/1", q_s, ovf_s, zero_s); end
        @(posedge clk); #1; rst = 1'b0;
        cycle(0, 1, 3'd1, 8'hA5);
        total++; if (q_w !== 8'hA5 || zero_w !== 1'b0) begin bad++;
            $display("FAIL load_a5 q=%02h zero=%0d want a5/0", q_w, zero_w); end
        // Pulse reset between edges and look before the next edge.
        #2; rst = 1'b1; #1;
        total++; if (q_w !== 8'h00 || zero_w !== 1'b1 || ovf_w !== 1'b0) begin bad++;
            $display("FAIL async_rst_w q=%02h zero=%0d ovf=%0d want 00/1/0", q_w, zero_w, ovf_w); end
        total++; if (q_s !== 8'h00 || zero_s !== 1'b1) begin bad++;
            $display("FAIL async_rst_s q=%02h zero=%0d want 00/1", q_s, zero_s); end
        #1; rst = 1'b0;
    endtask

    task automatic test_toggle();
        cycle(0, 1, 3'd1, 8'h0F);
        cycle(0, 1, 3'd2, 8'h3C);
        total++; if (q_w !== 8'h33) begin bad++; $display("FAIL toggle1 q=%02h want 33", q_w); end
        cycle(0, 1, 3'd2, 8'h3C);
        total++; if (q_w !== 8'h0F) begin bad++; $display("FAIL toggle2 q=%02h want 0f", q_w); end
        cycle(0, 1, 3'd2, 8'h00);
        total++; if (q_s !== 8'h0F || ovf_s !== 1'b0) begin bad++;
            $display("FAIL toggle0 q=%02h ovf=%0d want 0f/0", q_s, ovf_s); end
    endtask

    task automatic test_count();
        logic [7:0] exp_w [3] = '{8'hFF, 8'h00, 8'h01};
        logic       eov_w [3] = '{1'b0, 1'b1, 1'b0};
        logic       eov_s [3] = '{1'b0, 1'b1, 1'b1};
        cycle(0, 1, 3'd1, 8'hFE);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 3'd3, 8'h00);
            total++; if (q_w !== exp_w[i] || ovf_w !== eov_w[i]) begin bad++;
                $display("FAIL up_wrap_%0d q=%02h ovf=%0d want %02h/%0d", i, q_w, ovf_w, exp_w[i], eov_w[i]); end
            total++; if (q_s !== 8'hFF || ovf_s !== eov_s[i]) begin bad++;
                $display("FAIL up_sat_%0d q=%02h ovf=%0d want ff/%0d", i, q_s, ovf_s, eov_s[i]); end
        end
        cycle(0, 1, 3'd1, 8'h00);
        cycle(0, 1, 3'd4, 8'h00);
        total++; if (q_w !== 8'hFF || ovf_w !== 1'b1) begin bad++;
            $display("FAIL down_wrap q=%02h ovf=%0d want ff/1", q_w, ovf_w); end
        total++; if (q_s !== 8'h00 || ovf_s !== 1'b1 || zero_s !== 1'b1) begin bad++;
            $display("FAIL down_sat q=%02h ovf=%0d zero=%0d want 00/1/1", q_s, ovf_s, zero_s); end
        cycle(0, 1, 3'd0, 8'h00);
        total++; if (ovf_w !== 1'b0 || ovf_s !== 1'b0) begin bad++;
            $display("FAIL ovf_clear w=%0d s=%0d want 0/0", ovf_w, ovf_s); end
    endtask

    task automatic test_shift();
        cycle(0, 1, 3'd1, 8'h81);
        cycle(0, 1, 3'd5, 8'h01);
        total++; if (q_w !== 8'h03) begin bad++; $display("FAIL shl q=%02h want 03", q_w); end
        cycle(0, 1, 3'd6, 8'h80);
        total++; if (q_w !== 8'h81) begin bad++; $display("FAIL shr q=%02h want 81", q_w); end
        cycle(0, 1, 3'd7, 8'($urandom_range(0, 255)));
        total++; if (q_w !== 8'h03 || q_s !== 8'h03) begin bad++;
            $display("FAIL rol q_w=%02h q_s=%02h want 03", q_w, q_s); end
    endtask

    task automatic test_priority();
        cycle(1, 1, 3'd1, 8'h12);
        total++; if (q_w !== 8'hFF || ovf_w !== 1'b0) begin bad++;
            $display("FAIL set_wins q=%02h ovf=%0d want ff/0", q_w, ovf_w); end
        cycle(0, 0, 3'd3, 8'h00);
        total++; if (q_w !== 8'hFF || ovf_w !== 1'b0 || q_s !== 8'hFF) begin bad++;
            $display("FAIL en_hold q=%02h ovf=%0d want ff/0", q_w, ovf_w); end
        // rst together with set: reset must win.
        set = 1'b1; en = 1'b1; mode = 3'd1; d = 8'h55;
        #2; rst = 1'b1;
        @(posedge clk); #1;
        total++; if (q_w !== 8'h00 || q_s !== 8'h00) begin bad++;
            $display("FAIL rst_over_set q_w=%02h q_s=%02h want 00", q_w, q_s); end
        rst = 1'b0;
        // rst arriving during an UP at the limit: no ovf from the aborted edge.
        cycle(0, 1, 3'd1, 8'hFF);
        set = 1'b0; en = 1'b1; mode = 3'd3; d = 8'h00;
        #2; rst = 1'b1;
        @(posedge clk); #1;
        total++; if (ovf_w !== 1'b0 || ovf_s !== 1'b0 || q_s !== 8'h00) begin bad++;
            $display("FAIL rst_abort ovf_w=%0d ovf_s=%0d q_s=%02h want 0/0/00", ovf_w, ovf_s, q_s); end
        rst = 1'b0;
    endtask

    task automatic test_random();
        int mq [2];
        bit mo [2];
        int nq;
        bit no;
        bit s, e;
        int m, dd, sel;
        cycle(0, 1, 3'd1, 8'h5A);
        mq[0] = 8'h5A; mq[1] = 8'h5A; mo[0] = 1'b0; mo[1] = 1'b0;
        for (int i = 0; i < 400; i++) begin
            s   = ($urandom_range(0, 19) == 0);
            e   = ($urandom_range(0, 4) != 0);
            m   = $urandom_range(0, 7);
            sel = $urandom_range(0, 4);
            dd  = (sel == 0) ? 255 : (sel == 1) ? 0 : (sel == 2) ? 254 : int'($urandom_range(0, 255));
            for (int k = 0; k < 2; k++) begin
                ref_next(k == 0, mq[k], s, e, m, dd, nq, no);
                mq[k] = nq; mo[k] = no;
            end
            cycle(s, e, 3'(m), 8'(dd));
            total++; if (q_w !== 8'(mq[0]) || ovf_w !== mo[0] || zero_w !== (mq[0] == 0)) begin bad++;
                $display("FAIL rand_w_%0d q=%02h ovf=%0d zero=%0d want %02h/%0d/%0d",
                         i, q_w, ovf_w, zero_w, mq[0], mo[0], mq[0] == 0); end
            total++; if (q_s !== 8'(mq[1]) || ovf_s !== mo[1] || zero_s !== (mq[1] == 0)) begin bad++;
                $display("FAIL rand_s_%0d q=%02h ovf=%0d zero=%0d want %02h/%0d/%0d",
                         i, q_s, ovf_s, zero_s, mq[1], mo[1], mq[1] == 0); end
        end
    endtask

    initial begin
        test_reset();
        test_toggle();
        test_count();
        test_shift();
        test_priority();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mode_reg
